bus_move_sequencer: RTL and testbench
=====================================

Name: bus_move_sequencer

Overview:
- Microsequencer for the 8-bit internal bus of the 4-bit CPU datapath (PC, MAR, MDR, IR, ACC, BREG, TMP/C/D registers, IN/KEYCH/OUT registers, ROM).
- Runs fetch / decode / execute T-states and drives one-hot source-output-enables and destination-input-enables, with at most one bus driver per cycle.
- Lends the bus to one external requester (keypad/debug loader) at instruction boundaries.

Parameters:
- SRC_N, 8, number of bus sources (width of src_oen); fixed encoding, only 8 supported.
- DST_N, 8, number of bus destinations (width of dst_inen); only 8 supported.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE or HALT and begins fetch.
- ir_in  in  8  current IR contents.
- ext_req  in  1  external bus request, level, held until done.
- ext_gnt  out  1  bus granted to external requester.
- src_oen  out  SRC_N  one-hot bus driver select: 0 PC, 1 MDR, 2 ACC, 3 INREG, 4 KEYCH, 5 TMP, 6 CREG, 7 DREG.
- dst_inen  out  DST_N  one-hot bus load select: 0 MAR, 1 IR, 2 PC load, 3 BREG, 4 TMP, 5 CREG, 6 DREG, 7 OUTREG.
- rom_en  out  1  ROM read enable.
- mdr_inen  out  1  MDR capture from ROM.
- pc_inc  out  1  PC increment.
- busy  out  1  high in every state except IDLE, HALT and GRANT.
- halted  out  1  state == HALT.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  sticky; cleared only by reset.

Behaviour:
- Moore machine. All outputs decode combinationally from the registered state; the state updates on the clk rising edge.
- reset_n low clears state to IDLE at once, independent of clk. All outputs go to 0 and the illegal flag clears. This applies in the middle of any T-state, including GRANT.
- Instruction format (IR):
  - [7:6]=00: NOP.
  - [7:6]=01: MOV, with src=[5:3] and dst=[2:0].
  - [7:6]=10: JMP; the target address is in the next ROM byte.
  - 8'hFF: HLT.
  - Any other 11xxxxxx value: NOP, and sets illegal.
- States and per-state outputs:
  - IDLE: no outputs.
  - F1: src_oen[0], dst_inen[0] (PC to MAR).
  - F2: rom_en, mdr_inen, pc_inc.
  - F3: src_oen[1], dst_inen[1] (MDR to IR).
  - DEC: no enables; decodes ir_in.
  - MOV: src_oen[src], dst_inen[dst].
  - J1: PC to MAR.
  - J2: rom_en, mdr_inen, no pc_inc.
  - J3: MDR to PC load.
  - HALT: no outputs.
  - GRANT: ext_gnt only; src_oen, dst_inen, rom_en, mdr_inen and pc_inc all 0.
- Cycle counts:
  - NOP: F1-F2-F3-DEC, 4 cycles; instr_done in DEC.
  - MOV: 5 cycles; instr_done in MOV.
  - JMP: 7 cycles; instr_done in J3.
  - HLT: instr_done in DEC, then HALT next cycle.
- MOV with dst=1 (IR) is not executed: no enables, illegal set. src==dst is not possible on the bus and is not checked.
- Boundary decision, made on the last cycle of an instruction and in IDLE/HALT:
  - ext_req=1: go to GRANT; the return state is saved (F1, IDLE or HALT).
  - otherwise in IDLE/HALT: start=1 goes to F1, else stay.
  - otherwise at the end of an instruction: go to F1.
- ext_req has priority over start.
- GRANT stays while ext_req=1. The cycle after ext_req falls returns to the saved state, and ext_gnt is 0 in that cycle.
- ext_req is never granted in the middle of an instruction.
- Invariant in every state: popcount(src_oen) ≤ 1 and popcount(dst_inen) ≤ 1.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and state STEP_WAIT.
  - After every instr_done (except HLT), the machine enters STEP_WAIT instead of F1.
  - In STEP_WAIT, a step rising edge, detected with an internal registered copy, goes to F1. ext_req is still honoured there.
  - busy=0 in STEP_WAIT.
- When undefined: no step port and no STEP_WAIT state; behaviour is exactly as above.

Decomposition:
- Package bus_seq_pkg holds:
  - state enum;
  - source index constants SRC_PC..SRC_DREG;
  - destination index constants DST_MAR..DST_OUTREG;
  - opcode class constants OP_NOP, OP_MOV, OP_JMP, HLT_CODE.
- One sub-module, bus_seq_decode: purely combinational. It maps ir_in to {class, src, dst, is_hlt, is_illegal}. FSM and output decode stay in the top level.

Test Plan:
- Reset then start=1, ir_in=8'h00 throughout: F1 shows src_oen=8'h01 and dst_inen=8'h01; F2 shows rom_en, mdr_inen and pc_inc; F3 shows src_oen=8'h02 and dst_inen=8'h02; instr_done repeats every 4 cycles.
- ir_in=8'b01_010_101 (ACC to CREG): MOV cycle shows src_oen=8'h04 and dst_inen=8'h20; instr_done on cycle 5.
- ir_in=8'h80 (JMP): J1-J3 occur; J2 has pc_inc=0; J3 shows src_oen=8'h02 and dst_inen=8'h04; instr_done on cycle 7.
- ext_req raised in F2 and held 3 cycles: the instruction completes, then ext_gnt=1 for 3 cycles with all enables 0, then F1.
- ir_in=8'hFF: halted=1 and busy=0; start=1 resumes at F1. ir_in=8'hC3 or 8'b01_000_001 sets illegal, which stays set until reset_n pulses low.
- reset_n asserted asynchronously mid-J2: all outputs become 0 before the next clk edge, and state is IDLE.

Source files
------------

// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: shared state encoding, bus index constants and decoded-instruction type
// for the 8-bit internal-bus microsequencer. SEQ_SINGLE_STEP_EN adds the STEP_WAIT state.
package bus_seq_pkg;
  localparam int SRC_N = 8;
  localparam int DST_N = 8;
  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_DEC, S_MOV, S_J1, S_J2, S_J3, S_HALT,
`ifdef SEQ_SINGLE_STEP_EN
    S_STEP_WAIT,
`endif
    S_GRANT
  } state_t;
  localparam logic [2:0] SRC_PC = 3'd0, SRC_MDR = 3'd1, SRC_ACC = 3'd2, SRC_INREG = 3'd3;
  localparam logic [2:0] SRC_KEYCH = 3'd4, SRC_TMP = 3'd5, SRC_CREG = 3'd6, SRC_DREG = 3'd7;
  localparam logic [2:0] DST_MAR = 3'd0, DST_IR = 3'd1, DST_PC = 3'd2, DST_BREG = 3'd3;
  localparam logic [2:0] DST_TMP = 3'd4, DST_CREG = 3'd5, DST_DREG = 3'd6, DST_OUTREG = 3'd7;
  localparam logic [1:0] OP_NOP = 2'b00, OP_MOV = 2'b01, OP_JMP = 2'b10, OP_EXT = 2'b11;
  localparam logic [7:0] HLT_CODE = 8'hFF;
  typedef struct packed {
    logic [1:0] cls;
    logic [2:0] src;
    logic [2:0] dst;
    logic       is_hlt;
    logic       is_illegal;
  } dec_t;
endpackage

// File: rtl/bus_move_sequencer_if.sv
// bus_move_sequencer_if: sequencer <-> datapath signal bundle.
// master (sequencer): in start, ir_in, ext_req [, step]; out ext_gnt, src_oen, dst_inen,
// rom_en, mdr_inen, pc_inc, busy, halted, instr_done, illegal. slave is the mirror.
// SEQ_SINGLE_STEP_EN adds the step input.
interface bus_move_sequencer_if;
  import bus_seq_pkg::*;
  logic             start;
  logic [7:0]       ir_in;
  logic             ext_req;
  logic             ext_gnt;
  logic [SRC_N-1:0] src_oen;
  logic [DST_N-1:0] dst_inen;
  logic             rom_en;
  logic             mdr_inen;
  logic             pc_inc;
  logic             busy;
  logic             halted;
  logic             instr_done;
  logic             illegal;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step;
`endif
  modport master (
`ifdef SEQ_SINGLE_STEP_EN
    input step,
`endif
    input start, ir_in, ext_req,
    output ext_gnt, src_oen, dst_inen, rom_en, mdr_inen, pc_inc, busy, halted, instr_done, illegal
  );
  modport slave (
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    output start, ir_in, ext_req,
    input ext_gnt, src_oen, dst_inen, rom_en, mdr_inen, pc_inc, busy, halted, instr_done, illegal
  );
endinterface

// File: rtl/bus_seq_decode.sv
// bus_seq_decode: combinational IR decode.
// in ir_in[7:0]; out dec {cls, src, dst, is_hlt, is_illegal}; 11xxxxxx folds to NOP class.
module bus_seq_decode
  import bus_seq_pkg::*;
(
  input  logic [7:0] ir_in,
  output dec_t       dec
);
  always_comb begin
    dec.cls        = ir_in[7:6] == OP_EXT ? OP_NOP : ir_in[7:6];
    dec.src        = ir_in[5:3];
    dec.dst        = ir_in[2:0];
    dec.is_hlt     = ir_in == HLT_CODE;
    dec.is_illegal = (ir_in[7:6] == OP_EXT && ir_in != HLT_CODE) ||
                     (ir_in[7:6] == OP_MOV && ir_in[2:0] == DST_IR);
  end
endmodule

// File: rtl/bus_move_sequencer.sv
// bus_move_sequencer: fetch/decode/execute microsequencer for the 8-bit internal bus.
// in clk, reset_n (async, active low); bus (master modport): start, ir_in, ext_req in;
// one-hot src_oen/dst_inen, rom_en, mdr_inen, pc_inc, ext_gnt, busy, halted,
// instr_done, illegal out. SEQ_SINGLE_STEP_EN adds step input and STEP_WAIT state.
module bus_move_sequencer
  import bus_seq_pkg::*;
(
  input logic                  clk,
  input logic                  reset_n,
  bus_move_sequencer_if.master bus
);
  state_t state, state_d, ret, ret_d, after;
  logic   ill_q, mov_ok;
  dec_t   d;
  bus_seq_decode u_decode (.ir_in(bus.ir_in), .dec(d));
`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t CONT = S_STEP_WAIT;
  logic step_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) step_q <= 1'b0;
    else step_q <= bus.step;
`else
  localparam state_t CONT = S_F1;
`endif
  // where an instruction ending this cycle goes next (also the GRANT return point)
  assign after = (state == S_DEC && d.is_hlt) ? S_HALT : CONT;
  always_comb begin
    state_d = state;
    ret_d   = ret;
    case (state)
      S_IDLE, S_HALT:
        if (bus.ext_req) begin
          state_d = S_GRANT;
          ret_d   = state;
        end else if (bus.start) state_d = S_F1;
      S_F1: state_d = S_F2;
      S_F2: state_d = S_F3;
      S_F3: state_d = S_DEC;
      S_DEC, S_MOV, S_J3:
        if (state == S_DEC && d.cls == OP_MOV) state_d = S_MOV;
        else if (state == S_DEC && d.cls == OP_JMP) state_d = S_J1;
        else if (bus.ext_req) begin
          state_d = S_GRANT;
          ret_d   = after;
        end else state_d = after;
      S_J1: state_d = S_J2;
      S_J2: state_d = S_J3;
      S_GRANT: if (!bus.ext_req) state_d = ret;
`ifdef SEQ_SINGLE_STEP_EN
      S_STEP_WAIT:
        if (bus.ext_req) begin
          state_d = S_GRANT;
          ret_d   = S_STEP_WAIT;
        end else if (bus.step && !step_q) state_d = S_F1;
`endif
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      ret   <= S_IDLE;
      ill_q <= 1'b0;
    end else begin
      state <= state_d;
      ret   <= ret_d;
      ill_q <= ill_q | (state == S_DEC && d.is_illegal);
    end
  // MOV into IR would corrupt the instruction being executed, so it drives nothing
  assign mov_ok = state == S_MOV && !d.is_illegal;
  assign bus.src_oen = (state == S_F1 || state == S_J1) ? SRC_N'(1) << SRC_PC :
                       (state == S_F3 || state == S_J3) ? SRC_N'(1) << SRC_MDR :
                       mov_ok ? SRC_N'(1) << d.src : '0;
  assign bus.dst_inen = (state == S_F1 || state == S_J1) ? DST_N'(1) << DST_MAR :
                        state == S_F3 ? DST_N'(1) << DST_IR :
                        state == S_J3 ? DST_N'(1) << DST_PC :
                        mov_ok ? DST_N'(1) << d.dst : '0;
  assign bus.rom_en     = state == S_F2 || state == S_J2;
  assign bus.mdr_inen   = state == S_F2 || state == S_J2;
  assign bus.pc_inc     = state == S_F2;
  assign bus.ext_gnt    = state == S_GRANT;
  assign bus.halted     = state == S_HALT;
  assign bus.instr_done = (state == S_DEC && d.cls == OP_NOP) || state == S_MOV || state == S_J3;
  assign bus.illegal    = ill_q;
`ifdef SEQ_SINGLE_STEP_EN
  assign bus.busy = !(state inside {S_IDLE, S_HALT, S_GRANT, S_STEP_WAIT});
`else
  assign bus.busy = !(state inside {S_IDLE, S_HALT, S_GRANT});
`endif
endmodule

// File: tb/tb_bus_move_sequencer.sv
// tb_bus_move_sequencer: directed and random stimulus checked against an instruction-level model.
module tb_bus_move_sequencer;
  import bus_seq_pkg::*;
  typedef enum {M_IDLE, M_HALT, M_GRANT, M_INS} mode_t;
  logic  clk = 1'b0;
  logic  reset_n;
  int    passed = 0, total = 0, dones = 0;
  mode_t mode = M_IDLE, ret_mode = M_IDLE;
  int    k = 0;
  bit    m_ill = 1'b0;
  bus_move_sequencer_if bus ();
  bus_move_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic int ins_len(logic [7:0] ir);
    return ir[7:6] == 2'b01 ? 5 : ir[7:6] == 2'b10 ? 7 : 4;
  endfunction
  function automatic bit ins_ill(logic [7:0] ir);
    return (ir[7:6] == 2'b11 && ir != 8'hFF) || (ir[7:6] == 2'b01 && ir[2:0] == 3'd1);
  endfunction
  function automatic logic [7:0] rand_ir();
    int c;
    logic [5:0] b;
    c = $urandom_range(0, 9);
    b = 6'($urandom);
    return c < 2 ? {2'b00, b} : c < 6 ? {2'b01, b} : c < 8 ? {2'b10, b} : c == 8 ? 8'hFF : {2'b11, b};
  endfunction
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic check_now(string tag);
    logic [7:0] s, d, ir;
    bit rom, inc, done;
    s = 0; d = 0; rom = 0; inc = 0; done = 0;
    ir = bus.ir_in;
    if (mode == M_INS) begin
      if (k == 0 || (k == 4 && ir[7:6] == 2'b10)) begin s = 8'h01; d = 8'h01; end
      else if (k == 1) begin rom = 1; inc = 1; end
      else if (k == 2) begin s = 8'h02; d = 8'h02; end
      else if (k == 3) done = ins_len(ir) == 4;
      else if (k == 4) begin
        done = 1;
        if (!ins_ill(ir)) begin s = 8'h01 << ir[5:3]; d = 8'h01 << ir[2:0]; end
      end
      else if (k == 5) rom = 1;
      else begin s = 8'h02; d = 8'h04; done = 1; end
    end
    chk({tag, "_src"}, bus.src_oen, s);
    chk({tag, "_dst"}, bus.dst_inen, d);
    chk({tag, "_ctl"},
        {bus.rom_en, bus.mdr_inen, bus.pc_inc, bus.ext_gnt, bus.busy, bus.halted, bus.instr_done, bus.illegal},
        {rom, rom, inc, mode == M_GRANT, mode == M_INS, mode == M_HALT, done, m_ill});
  endtask
  task automatic advance();
    logic [7:0] ir;
    ir = bus.ir_in;
    case (mode)
      M_IDLE, M_HALT:
        if (bus.ext_req) begin ret_mode = mode; mode = M_GRANT; end
        else if (bus.start) begin mode = M_INS; k = 0; end
      M_GRANT: if (!bus.ext_req) begin mode = ret_mode; k = 0; end
      default: begin
        if (k == 3 && ins_ill(ir)) m_ill = 1'b1;
        if (k < ins_len(ir) - 1) k++;
        else begin
          ret_mode = ir == 8'hFF ? M_HALT : M_INS;
          k = 0;
          mode = bus.ext_req ? M_GRANT : ret_mode;
        end
      end
    endcase
  endtask
  task automatic cyc(bit s, bit r, logic [7:0] ir, string tag);
    bus.start = s;
    bus.ext_req = r;
    bus.ir_in = ir;
    advance();
    @(posedge clk);
    @(negedge clk);
    check_now(tag);
  endtask
  task automatic do_reset(string tag);
    reset_n = 1'b0;
    mode = M_IDLE;
    ret_mode = M_IDLE;
    m_ill = 1'b0;
    k = 0;
    #1 check_now(tag);
    #1 reset_n = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.ext_req = 1'b0;
    bus.ir_in = 8'h00;
    @(negedge clk);
    do_reset("rst0");
    cyc(1, 0, 8'h00, "nop");
    chk("nop_f1_src", bus.src_oen, 8'h01);
    chk("nop_f1_dst", bus.dst_inen, 8'h01);
    cyc(1, 0, 8'h00, "nop");
    chk("nop_f2_ctl", {5'b0, bus.rom_en, bus.mdr_inen, bus.pc_inc}, 8'h07);
    cyc(1, 0, 8'h00, "nop");
    chk("nop_f3_src", bus.src_oen, 8'h02);
    chk("nop_f3_dst", bus.dst_inen, 8'h02);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 8'h00, "nop");
      dones += int'(bus.instr_done);
    end
    chk("nop_done_cnt", 8'(dones), 8'd2);
    do_reset("rst_mov");
    repeat (4) cyc(1, 0, 8'h55, "mov");
    chk("mov_done_early", {7'b0, bus.instr_done}, 8'h00);
    cyc(1, 0, 8'h55, "mov");
    chk("mov_src", bus.src_oen, 8'h04);
    chk("mov_dst", bus.dst_inen, 8'h20);
    chk("mov_done", {7'b0, bus.instr_done}, 8'h01);
    do_reset("rst_jmp");
    repeat (5) cyc(1, 0, 8'h80, "jmp");
    cyc(1, 0, 8'h80, "jmp");
    chk("j2_ctl", {5'b0, bus.rom_en, bus.mdr_inen, bus.pc_inc}, 8'h06);
    cyc(1, 0, 8'h80, "jmp");
    chk("j3_src", bus.src_oen, 8'h02);
    chk("j3_dst", bus.dst_inen, 8'h04);
    chk("j3_done", {7'b0, bus.instr_done}, 8'h01);
    do_reset("rst_ext");
    cyc(1, 0, 8'h00, "ext");
    repeat (3) cyc(1, 1, 8'h00, "ext");
    chk("ext_dec_done", {bus.ext_gnt, bus.instr_done}, 8'h01);
    repeat (3) begin
      cyc(1, 1, 8'h00, "grant");
      chk("grant_gnt", {7'b0, bus.ext_gnt}, 8'h01);
      chk("grant_src", bus.src_oen, 8'h00);
    end
    cyc(1, 0, 8'h00, "ext_ret");
    chk("ext_ret_gnt", {7'b0, bus.ext_gnt}, 8'h00);
    chk("ext_ret_src", bus.src_oen, 8'h01);
    do_reset("rst_hlt");
    repeat (4) cyc(1, 0, 8'hFF, "hlt");
    cyc(0, 0, 8'hFF, "hlt");
    chk("hlt_halted_busy", {bus.halted, bus.busy}, 8'h02);
    cyc(0, 0, 8'hFF, "hlt_stay");
    cyc(1, 0, 8'hFF, "hlt_resume");
    chk("hlt_resume_src", bus.src_oen, 8'h01);
    do_reset("rst_ill");
    repeat (5) cyc(1, 0, 8'hC3, "ill");
    chk("ill_set", {7'b0, bus.illegal}, 8'h01);
    repeat (5) cyc(1, 0, 8'h00, "ill_keep");
    chk("ill_sticky", {7'b0, bus.illegal}, 8'h01);
    do_reset("rst_ill_clr");
    chk("ill_clr", {7'b0, bus.illegal}, 8'h00);
    repeat (5) cyc(1, 0, 8'h41, "movir");
    chk("movir_src", bus.src_oen, 8'h00);
    chk("movir_dst", bus.dst_inen, 8'h00);
    cyc(1, 0, 8'h41, "movir");
    chk("movir_ill", {7'b0, bus.illegal}, 8'h01);
    do_reset("rst_pre_j2");
    repeat (6) cyc(1, 0, 8'h80, "j2run");
    do_reset("rst_j2");
    chk("rst_j2_state", 8'(dut.state), 8'(S_IDLE));
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ir;
      bit r;
      ir = bus.ir_in;
      r = bus.ext_req;
      if (!r) r = $urandom_range(0, 9) == 0;
      else if (mode == M_GRANT) r = $urandom_range(0, 2) != 0;
      if ((mode != M_INS || k <= 3) && $urandom_range(0, 1) == 1) ir = rand_ir();
      if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
      else cyc($urandom_range(0, 3) != 0, r, ir, "rnd");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
